// File: rtl/haz_pkg.sv
// Shared widths, constants and FSM state encoding for the fetch hazard controller.
package haz_pkg;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   localparam int STALL_CNT_W = 2;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      HALT  = 2'd2
   } haz_state_e;
endpackage

// File: rtl/haz_reg_match.sv
// Register-match comparator: hit when dst equals rs (or rt when use_rt), never for r0.
// Purely combinational, no flow control.
module haz_reg_match
   import haz_pkg::*;
(
   input  logic [REG_W-1:0] dst,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic             use_rt,
   output logic             hit
);

   assign hit = (dst != REG_ZERO) && ((dst == rs) || (use_rt && (dst == rt)));

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch/IF-ID sequencing with load-use and branch-operand stalls, redirect and halt.
// Mealy outputs, zero latency; optional counters under HAZ_STATS_EN.
module fetch_hazard_ctrl
   import haz_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             id_is_branch,
   input  logic             branch_taken,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             mem_mem_read,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             halt_req,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             Flush,
   output logic             MuxBranchControl,
   output logic             idex_bubble
`ifdef HAZ_STATS_EN
   ,
   output logic [31:0]      stall_count,
   output logic [31:0]      flush_count
`endif
);

   haz_state_e             state_q, state_d;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
   logic                   ex_hit, ex_hit_br, mem_hit_br;
   logic                   lu2, lu1, br1;
   logic                   eval_run, redirect;

   haz_reg_match u_match_ex (
      .dst(ex_rd), .rs(id_rs), .rt(id_rt), .use_rt(id_uses_rt), .hit(ex_hit)
   );
   haz_reg_match u_match_ex_br (
      .dst(ex_rd), .rs(id_rs), .rt(id_rt), .use_rt(1'b1), .hit(ex_hit_br)
   );
   haz_reg_match u_match_mem_br (
      .dst(mem_rd), .rs(id_rs), .rt(id_rt), .use_rt(1'b1), .hit(mem_hit_br)
   );

   assign lu2 = id_is_branch && ex_mem_read && ex_hit_br;
   assign lu1 = ex_mem_read && ex_hit;
   assign br1 = id_is_branch && ((ex_reg_write && ex_hit_br) || (mem_mem_read && mem_hit_br));

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      PCWrite          = 1'b0;
      IFIDWrite        = 1'b0;
      Flush            = 1'b0;
      MuxBranchControl = 1'b0;
      idex_bubble      = 1'b1;
      eval_run         = 1'b0;
      redirect         = 1'b0;
      if (!rst_n) begin
         state_d = RUN;
         cnt_d   = '0;
      end else if (halt_req) begin
         state_d = HALT;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            HALT: begin
               state_d = RUN;
               cnt_d   = '0;
            end
            // stall_cnt counts forced cycles still owed; at zero this is the release cycle
            STALL: begin
               if (cnt_q != '0) cnt_d = cnt_q - STALL_CNT_W'(1);
               else             eval_run = 1'b1;
            end
            default: eval_run = 1'b1;
         endcase
         if (eval_run) begin
            state_d = RUN;
            cnt_d   = '0;
            if (lu2) begin
               state_d = STALL;
               cnt_d   = STALL_CNT_W'(1);
            end else if (lu1 || br1) begin
               state_d = STALL;
            end else begin
               PCWrite     = 1'b1;
               IFIDWrite   = 1'b1;
               idex_bubble = 1'b0;
               if (id_is_branch && branch_taken) begin
                  Flush            = 1'b1;
                  MuxBranchControl = 1'b1;
                  redirect         = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZ_STATS_EN
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] flush_count_q, flush_count_d;

   // halt-driven bubbles are not hazard stalls
   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (idex_bubble && !halt_req && (state_q != HALT)) stall_count_d = stall_count_q + 32'd1;
      if (redirect) flush_count_d = flush_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl: directed scenarios then random traffic against a cycle model.
module tb_fetch_hazard_ctrl;
   logic       clk;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       id_uses_rt, id_is_branch, branch_taken;
   logic       ex_mem_read, ex_reg_write, mem_mem_read, halt_req;
   logic       PCWrite, IFIDWrite, Flush, MuxBranchControl, idex_bubble;
`ifdef HAZ_STATS_EN
   logic [31:0] stall_count, flush_count;
`endif

   int n_chk = 0;
   int n_err = 0;

   // model: owed stall cycles, halted flag, stats
   int          m_rem = 0;
   bit          m_halt = 0;
   bit          m_known = 0;
   int unsigned m_stalls = 0;
   int unsigned m_flushes = 0;

   fetch_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_is_branch(id_is_branch), .branch_taken(branch_taken),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .halt_req(halt_req),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .Flush(Flush),
      .MuxBranchControl(MuxBranchControl), .idex_bubble(idex_bubble)
`ifdef HAZ_STATS_EN
      , .stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit hit(input logic [4:0] r, input bit both);
      return (r != 5'd0) && ((r == id_rs) || (both && (r == id_rt)));
   endfunction

   task automatic clr();
      id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
      id_uses_rt = 0; id_is_branch = 0; branch_taken = 0;
      ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 0; halt_req = 0;
      rst_n = 1;
   endtask

   // Inputs already applied; check at negedge, advance the model at posedge.
   task automatic run_cycle(input string tag);
      logic [4:0] exp_o, got;
      int n_rem;
      bit n_halt, st, fl, lu2, lu1, br1;
      @(negedge clk);
      exp_o = 5'b00001; n_rem = m_rem; n_halt = m_halt; st = 0; fl = 0;
      lu2 = id_is_branch && ex_mem_read && hit(ex_rd, 1'b1);
      lu1 = ex_mem_read && hit(ex_rd, id_uses_rt);
      br1 = id_is_branch && ((ex_reg_write && hit(ex_rd, 1'b1)) || (mem_mem_read && hit(mem_rd, 1'b1)));
      if (!rst_n) begin
         n_rem = 0; n_halt = 0;
      end else if (halt_req) begin
         n_rem = 0; n_halt = 1;
      end else if (m_halt) begin
         n_rem = 0; n_halt = 0;
      end else if (m_rem > 0) begin
         n_rem = m_rem - 1; st = 1;
      end else if (lu2) begin
         n_rem = 1; st = 1;
      end else if (lu1 || br1) begin
         n_rem = 0; st = 1;
      end else if (id_is_branch && branch_taken) begin
         exp_o = 5'b11110; fl = 1;
      end else begin
         exp_o = 5'b11000;
      end
      got = {PCWrite, IFIDWrite, Flush, MuxBranchControl, idex_bubble};
      chk(tag, 32'(got), 32'(exp_o));
`ifdef HAZ_STATS_EN
      if (m_known) begin
         chk({tag, "_stallcnt"}, stall_count, m_stalls);
         chk({tag, "_flushcnt"}, flush_count, m_flushes);
      end
`endif
      @(posedge clk);
      m_rem = n_rem; m_halt = n_halt;
      if (!rst_n) begin
         m_stalls = 0; m_flushes = 0; m_known = 1;
      end else begin
         m_stalls  += 32'(st);
         m_flushes += 32'(fl);
      end
      #1;
   endtask

   task automatic do_reset();
      clr(); rst_n = 0;
      run_cycle("reset");
      clr();
   endtask

   initial begin
      clr(); rst_n = 0;
      run_cycle("reset0");
      run_cycle("reset1");

      // load-use: one stall, then the bubble in ID/EX clears the hazard
      clr(); ex_mem_read = 1; ex_rd = 8; id_rs = 8;
      run_cycle("lu1_stall");
      clr(); id_rs = 8;
      run_cycle("lu1_release");

      // branch after load: two stalls, then a clean taken branch redirects once
      clr(); id_is_branch = 1; ex_mem_read = 1; ex_rd = 9; id_rt = 9;
      run_cycle("lu2_stall0");
      clr(); id_is_branch = 1; id_rt = 9;
      run_cycle("lu2_stall1");
      branch_taken = 1;
      run_cycle("lu2_redirect");
      clr();
      run_cycle("after_redirect");

      // r0 never matches
      clr(); ex_mem_read = 1; ex_rd = 0; id_rs = 0;
      run_cycle("zero_mask");

      // halt in the middle of a two-cycle stall
      clr(); id_is_branch = 1; ex_mem_read = 1; ex_rd = 9; id_rt = 9;
      run_cycle("halt_pre");
      clr(); halt_req = 1;
      for (int i = 0; i < 3; i++) run_cycle("halt_hold");
      halt_req = 0;
      run_cycle("halt_exit");
      run_cycle("halt_run");

      // reset during a stall
      clr(); ex_mem_read = 1; ex_rd = 3; id_rt = 3; id_uses_rt = 1;
      run_cycle("rst_pre");
      clr(); rst_n = 0;
      run_cycle("rst_mid");
      clr();
      run_cycle("rst_run");
`ifdef HAZ_STATS_EN
      chk("rst_stall_zero", stall_count, 32'd0);
`endif

      // 5 redirects and 3 load-use stalls from a fresh reset
      do_reset();
      for (int i = 0; i < 5; i++) begin
         clr(); id_is_branch = 1; branch_taken = 1; id_rs = 5'(i + 1);
         run_cycle("stats_redirect");
      end
      for (int i = 0; i < 3; i++) begin
         clr(); ex_mem_read = 1; ex_rd = 5'(i + 4); id_rs = 5'(i + 4);
         run_cycle("stats_lu");
         clr();
         run_cycle("stats_clean");
      end
`ifdef HAZ_STATS_EN
      chk("stats_flush", flush_count, 32'd5);
      chk("stats_stall", stall_count, 32'd3);
`endif

      // random traffic over a small register range to provoke matches
      for (int i = 0; i < 2000; i++) begin
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         ex_rd        = 5'($urandom_range(0, 3));
         mem_rd       = 5'($urandom_range(0, 3));
         id_uses_rt   = 1'($urandom_range(0, 1));
         id_is_branch = ($urandom_range(0, 9) < 4);
         branch_taken = 1'($urandom_range(0, 1));
         ex_mem_read  = ($urandom_range(0, 9) < 3);
         ex_reg_write = 1'($urandom_range(0, 1));
         mem_mem_read = ($urandom_range(0, 9) < 3);
         halt_req     = ($urandom_range(0, 99) < 6);
         rst_n        = ($urandom_range(0, 99) >= 2);
         run_cycle("random");
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
